// File: rtl/tx_lane_sched.sv
// tx_lane_sched: four-lane byte scheduler feeding a parallel-to-serial stage.
// After reset it sends SYNC_LEN COM characters, then grants one requesting lane
// per cycle round-robin, with IDL fill when nothing is pending or the link is idle.
// Optional feature: define TX_LANE_SCHED_PRIO_EN to make lane 0 strict priority.
module tx_lane_sched #(
  parameter int unsigned SYNC_LEN = 4,
  parameter logic [7:0]  COM_BYTE = 8'hBC,
  parameter logic [7:0]  IDL_BYTE = 8'h7C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       IDLE,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       k_out,
  output logic [1:0] lane_out,
  output logic [1:0] state_out
);

  localparam logic [1:0] StRst    = 2'b00;
  localparam logic [1:0] StSync   = 2'b01;
  localparam logic [1:0] StActive = 2'b10;
  localparam logic [1:0] StHold   = 2'b11;

  // Last count value of the SYNC phase (counter starts at 0 on entry).
  localparam logic [3:0] SyncLast = 4'(SYNC_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       k_q, k_d;
  logic [1:0] lane_q, lane_d;

  logic [3:0] valid_vec;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] gnt_ptr_next;
  logic [7:0] gnt_data;
  logic       gnt_en;
  logic [3:0] ready_vec;

  assign valid_vec = {valid_in3, valid_in2, valid_in1, valid_in0};

  // Pick the first requesting lane starting at the round-robin pointer.
  always_comb begin
    logic [1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!gnt_any && valid_vec[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
`ifdef TX_LANE_SCHED_PRIO_EN
    if (valid_in0) begin
      gnt_any = 1'b1;
      gnt_idx = 2'd0;
    end
`endif
  end

  // Pointer after a grant; a priority grant to lane 0 leaves it in place.
  always_comb begin
`ifdef TX_LANE_SCHED_PRIO_EN
    gnt_ptr_next = (gnt_idx == 2'd0) ? rr_ptr_q : gnt_idx + 2'd1;
`else
    gnt_ptr_next = gnt_idx + 2'd1;
`endif
  end

  // Data mux for the granted lane.
  always_comb begin
    gnt_data = in0;
    case (gnt_idx)
      2'd0:    gnt_data = in0;
      2'd1:    gnt_data = in1;
      2'd2:    gnt_data = in2;
      default: gnt_data = in3;
    endcase
  end

  // Combinational one-hot grant; only in ACTIVE, never under IDLE or reset.
  always_comb begin
    gnt_en    = (state_q == StActive) && !IDLE && !reset && gnt_any;
    ready_vec = 4'b0000;
    if (gnt_en) begin
      ready_vec = 4'b0001 << gnt_idx;
    end
  end

  assign ready0 = ready_vec[0];
  assign ready1 = ready_vec[1];
  assign ready2 = ready_vec[2];
  assign ready3 = ready_vec[3];

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sync_cnt_d = sync_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    k_d        = 1'b0;
    lane_d     = lane_q;
    case (state_q)
      StRst: begin
        state_d    = StSync;
        sync_cnt_d = 4'd0;
        data_d     = COM_BYTE;
        k_d        = 1'b1;
      end
      StSync: begin
        data_d = COM_BYTE;
        k_d    = 1'b1;
        if (sync_cnt_q == SyncLast) begin
          // IDLE is deliberately ignored here; HOLD is only reachable from ACTIVE.
          state_d = StActive;
          data_d  = IDL_BYTE;
        end else begin
          sync_cnt_d = sync_cnt_q + 4'd1;
        end
      end
      StActive: begin
        if (IDLE) begin
          state_d = StHold;
          data_d  = IDL_BYTE;
          k_d     = 1'b1;
        end else if (gnt_any) begin
          data_d   = gnt_data;
          valid_d  = 1'b1;
          lane_d   = gnt_idx;
          rr_ptr_d = gnt_ptr_next;
        end else begin
          data_d = IDL_BYTE;
          k_d    = 1'b1;
        end
      end
      default: begin
        data_d = IDL_BYTE;
        k_d    = 1'b1;
        if (!IDLE) begin
          state_d = StActive;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q    <= StRst;
      rr_ptr_q   <= 2'd0;
      sync_cnt_q <= 4'd0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      k_q        <= 1'b0;
      lane_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sync_cnt_q <= sync_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      k_q        <= k_d;
      lane_q     <= lane_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign k_out     = k_q;
  assign lane_out  = lane_q;
  assign state_out = state_q;

endmodule

// File: doc/tx_lane_sched.md
TX_LANE_SCHED -- requirements
Module: tx_lane_sched

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 4, giving the number of COM bytes sent after reset before data (range 1..15).
REQ-002 SHALL have parameter COM_BYTE, default 8'hBC, the comma/sync control character.
REQ-003 SHALL have parameter IDL_BYTE, default 8'h7C, the idle control character.
REQ-004 SHALL have port clk_4f, input, 1 bit: the single byte-rate clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port IDLE, input, 1 bit: link-idle request; data is suspended while it is high.
REQ-007 SHALL have ports valid_in0..valid_in3, input, 1 bit each: lane i holds a byte.
REQ-008 SHALL have ports in0..in3, input, 8 bits each: lane i data byte.
REQ-009 SHALL have ports ready0..ready3, output, 1 bit each: combinational grant; lane i's byte is consumed this cycle.
REQ-010 SHALL have port data_out, output, 8 bits: registered byte to the parallel-to-serial stage.
REQ-011 SHALL have port valid_out, output, 1 bit: registered; data_out carries lane data.
REQ-012 SHALL have port k_out, output, 1 bit: registered; data_out is a control character (COM/IDL).
REQ-013 SHALL have port lane_out, output, 2 bits: registered; source lane of the current data_out, valid only when valid_out=1.
REQ-014 SHALL have port state_out, output, 2 bits: current FSM state (00 RST, 01 SYNC, 10 ACTIVE, 11 HOLD).

Function
REQ-015 SHALL implement FSM RST -> SYNC -> ACTIVE <-> HOLD; RST is entered only through reset.
REQ-016 In RST, the first cycle after reset deasserts SHALL move to SYNC and clear the sync counter.
REQ-017 SYNC SHALL emit COM_BYTE with k_out=1 and valid_out=0 for exactly SYNC_LEN cycles, then enter ACTIVE regardless of IDLE.
REQ-018 In ACTIVE with IDLE=0, the block SHALL grant exactly one requesting lane per cycle, round-robin starting at rr_ptr (2 bits).
REQ-019 The granted lane's readyN SHALL be 1 in the same cycle; all other readies SHALL be 0.
REQ-020 Next cycle: data_out=inN, valid_out=1, k_out=0, lane_out=N (latency 1 cycle).
REQ-021 After a grant to lane N, rr_ptr SHALL become (N+1) mod 4, wrapping from 3 to 0.
REQ-022 In ACTIVE with no valid_in asserted: ready all 0, next data_out=IDL_BYTE, k_out=1, valid_out=0, rr_ptr unchanged.
REQ-023 IDLE=1 in ACTIVE SHALL suppress all readies that same cycle and move to HOLD.
REQ-024 HOLD SHALL emit IDL_BYTE with k_out=1, valid_out=0, readies 0; IDLE=0 SHALL return to ACTIVE, granting from the next cycle.
REQ-025 ready0..3 SHALL be 0 in RST, SYNC and HOLD; readies SHALL never be multi-hot.
REQ-026 valid_in with IDLE=1 on the same edge: IDLE wins and no byte is consumed.

Reset
REQ-027 reset=1 at any cycle, including mid-SYNC or mid-grant, SHALL on that edge set: state RST, rr_ptr 0, sync counter 0, data_out 8'h00, valid_out 0, k_out 0, lane_out 0.
REQ-028 Readies SHALL be 0 whenever reset=1.

Configuration
REQ-029 Macro TX_LANE_SCHED_PRIO_EN, when defined, SHALL make lane 0 strict priority: any cycle with valid_in0=1 in ACTIVE grants lane 0 and leaves rr_ptr unchanged; lanes 1-3 use round-robin otherwise.
REQ-030 With TX_LANE_SCHED_PRIO_EN undefined, all four lanes SHALL be plain round-robin per REQ-018..021.

Verification
REQ-031 Reset 2 cycles, IDLE=0, no valids -> 4 cycles data_out=BC k_out=1, then continuous 7C k_out=1, state_out 01 then 10.
REQ-032 ACTIVE, all valids=1, in0..3=A0,A1,A2,A3 for 8 cycles -> grants 0,1,2,3,0,1,2,3; data_out A0,A1,A2,A3,... each 1 cycle after its ready.
REQ-033 Only valid_in2=1 (in2=55) for 3 cycles, then valid_in1 also 1 -> grant 2,2,2, then 1 (pointer at 3 wraps: 3 idle, 0 idle, 1 valid).
REQ-034 IDLE=1 for 3 cycles during all-valid traffic -> no readies that cycle, 3 cycles 7C k_out=1 in HOLD, traffic resumes at rr_ptr unchanged.
REQ-035 reset pulsed during SYNC cycle 2 and during traffic -> outputs zero next edge, full SYNC_LEN COM sequence restarts.
REQ-036 With TX_LANE_SCHED_PRIO_EN, all valids=1 -> lane 0 granted every cycle; drop valid_in0 -> round-robin among 1-3.
